// File: rtl/platform_pool.sv
// Platform pool: stores N_BLOCKS platform (x, y) slots, lays them out on reset,
// and on each scroll event relocates any platform that has dropped fully below
// the bottom of the view to a pseudo-random spot above the current top.
module platform_pool #(
    parameter int          SCREEN_WIDTH  = 400,
    parameter int          SCREEN_HEIGHT = 700,
    parameter int          BLOCK_WIDTH   = 40,
    parameter int          BLOCK_HEIGHT  = 5,
    parameter int          N_BLOCKS      = 16,
    parameter int          INIT_GAP      = 40,
    parameter int          MIN_GAP       = 30,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    localparam int         IDX_W         = $clog2(N_BLOCKS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             newView,
    input  logic [31:0]      minY,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [9:0]       rd_x,
    output logic [31:0]      rd_y,
    output logic [31:0]      top_y,
    output logic             busy,
    output logic             recycle,
    output logic             scan_done
);

    localparam int XRANGE = SCREEN_WIDTH - BLOCK_WIDTH;

    // Catch parameter sets the x-wrap and LFSR logic cannot handle.
    if (XRANGE < 256 || XRANGE >= 512 || LFSR_SEED == 16'h0000 ||
        SCREEN_HEIGHT < BLOCK_HEIGHT) begin : g_bad_params
        $error("platform_pool: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             pending_q, pending_d;
    logic [31:0]      min_y_l_q, min_y_l_d;
    logic [31:0]      top_y_q, top_y_d;
    logic [9:0]       x_acc_q, x_acc_d;
    logic             recycle_q, recycle_d;
    logic             scan_done_q, scan_done_d;
    logic [9:0]       rd_x_q;
    logic [31:0]      rd_y_q;

    // Slot storage: written one slot per cycle, read by the scan and the read port.
    logic [9:0]  x_mem [N_BLOCKS];
    logic [31:0] y_mem [N_BLOCKS];

    logic        wr_en;
    logic [9:0]  wr_x;
    logic [31:0] wr_y;

    logic        last_slot;
    logic        hit;
    logic [31:0] init_y;
    logic [9:0]  x_acc_sum;
    logic [9:0]  x_acc_step;
    logic [31:0] y_new;
    logic [9:0]  r_raw;
    logic [9:0]  x_new;
    logic        lfsr_fb;

    // Datapath helpers for init layout, recycle placement and LFSR feedback.
    always_comb begin
        last_slot  = (idx_q == IDX_W'(N_BLOCKS - 1));
        init_y     = 32'(INIT_GAP) * {{(32-IDX_W){1'b0}}, idx_q};
        x_acc_sum  = x_acc_q + 10'd47;
        x_acc_step = (x_acc_sum >= 10'(XRANGE)) ? (x_acc_sum - 10'(XRANGE)) : x_acc_sum;
        // 33-bit compare so y near the top of the range cannot wrap into a false hit.
        hit        = ({1'b0, y_mem[idx_q]} + 33'(BLOCK_HEIGHT)) <= {1'b0, min_y_l_q};
        y_new      = top_y_q + 32'(MIN_GAP) + {26'd0, lfsr_q[5:0]};
        r_raw      = {1'b0, lfsr_q[8:0]};
        x_new      = (r_raw >= 10'(XRANGE)) ? (r_raw - 10'(XRANGE)) : r_raw;
        lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    // Next-state logic for the INIT / IDLE / SCAN controller.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lfsr_d      = lfsr_q;
        pending_d   = pending_q;
        min_y_l_d   = min_y_l_q;
        top_y_d     = top_y_q;
        x_acc_d     = x_acc_q;
        recycle_d   = 1'b0;
        scan_done_d = 1'b0;
        wr_en       = 1'b0;
        wr_x        = '0;
        wr_y        = '0;

        case (state_q)
            S_INIT: begin
                wr_en   = 1'b1;
                wr_x    = x_acc_q;
                wr_y    = init_y;
                x_acc_d = x_acc_step;
                idx_d   = idx_q + 1'b1;
                if (newView) pending_d = 1'b1;
                if (last_slot) begin
                    idx_d = '0;
                    // An event seen during (or on the last cycle of) init starts a scan.
                    if (pending_q || newView) begin
                        state_d   = S_SCAN;
                        pending_d = 1'b0;
                        min_y_l_d = minY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                if (newView) begin
                    min_y_l_d = minY;
                    idx_d     = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (newView) pending_d = 1'b1;
                if (hit) begin
                    wr_en     = 1'b1;
                    wr_x      = x_new;
                    wr_y      = y_new;
                    top_y_d   = y_new;
                    lfsr_d    = {lfsr_q[14:0], lfsr_fb};
                    recycle_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (last_slot) begin
                    scan_done_d = 1'b1;
                    idx_d       = '0;
                    // Coalesced events run back-to-back as one extra scan.
                    if (pending_q || newView) begin
                        pending_d = 1'b0;
                        min_y_l_d = minY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Control registers and the registered read port, reset synchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            lfsr_q      <= LFSR_SEED;
            pending_q   <= 1'b0;
            min_y_l_q   <= '0;
            top_y_q     <= 32'((N_BLOCKS - 1) * INIT_GAP);
            x_acc_q     <= '0;
            recycle_q   <= 1'b0;
            scan_done_q <= 1'b0;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lfsr_q      <= lfsr_d;
            pending_q   <= pending_d;
            min_y_l_q   <= min_y_l_d;
            top_y_q     <= top_y_d;
            x_acc_q     <= x_acc_d;
            recycle_q   <= recycle_d;
            scan_done_q <= scan_done_d;
            rd_x_q      <= x_mem[rd_idx];
            rd_y_q      <= y_mem[rd_idx];
        end
    end

    // Slot write; reset blocks writes, INIT rebuilds the contents afterwards.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            x_mem[idx_q] <= wr_x;
            y_mem[idx_q] <= wr_y;
        end
    end

    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign top_y     = top_y_q;
    assign busy      = (state_q != S_IDLE);
    assign recycle   = recycle_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_platform_pool.sv
// Directed bench for platform_pool: reset layout, scans with and without
// recycling, coalesced back-to-back scans, reset mid-scan, read-port sweep.
module tb_platform_pool;

    logic        clk;
    logic        reset;
    logic        newView;
    logic [31:0] minY;
    logic [3:0]  rd_idx;
    logic [9:0]  rd_x;
    logic [31:0] rd_y;
    logic [31:0] top_y;
    logic        busy;
    logic        recycle;
    logic        scan_done;

    int total_cnt  = 0;
    int passed_cnt = 0;
    int failed_cnt = 0;

    platform_pool dut (
        .clk       (clk),
        .reset     (reset),
        .newView   (newView),
        .minY      (minY),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .top_y     (top_y),
        .busy      (busy),
        .recycle   (recycle),
        .scan_done (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            failed_cnt++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_slot(input int i, output logic [9:0] x, output logic [31:0] y);
        rd_idx = 4'(i);
        step();
        x = rd_x;
        y = rd_y;
    endtask

    // Pulse newView, then run until busy drops (bounded), counting pulses.
    task automatic run_scan(input logic [31:0] min_y, output int cycles,
                            output int dones, output int recs);
        minY    = min_y;
        newView = 1'b1;
        step();
        newView = 1'b0;
        cycles  = busy ? 1 : 0;
        dones   = 0;
        recs    = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (scan_done) dones++;
            if (recycle) recs++;
            if (!busy) break;
            cycles++;
        end
    endtask

    initial begin
        logic [9:0]  x;
        logic [31:0] y;
        int cycles, dones, recs, first_done, second_done, busy_cnt;

        reset   = 1'b1;
        newView = 1'b0;
        minY    = 32'd0;
        rd_idx  = 4'd0;

        // 1. reset values, init duration, init layout
        step();
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_recycle", 32'(recycle), 32'd0);
        check("reset_scan_done", 32'(scan_done), 32'd0);
        check("reset_rd_x", 32'(rd_x), 32'd0);
        check("reset_rd_y", rd_y, 32'd0);
        check("reset_top_y", top_y, 32'd600);
        reset    = 1'b0;
        busy_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) break;
            busy_cnt++;
        end
        check("init_busy_cycles", 32'(busy_cnt), 32'd16);
        read_slot(5, x, y);
        check("init_slot5_x", 32'(x), 32'd235);
        check("init_slot5_y", y, 32'd200);
        read_slot(9, x, y);
        check("init_slot9_x", 32'(x), 32'd63);
        check("init_slot9_y", y, 32'd360);
        check("init_top_y", top_y, 32'd600);

        // 2. scan with minY=0: nothing recycles
        run_scan(32'd0, cycles, dones, recs);
        check("scan0_cycles", 32'(cycles), 32'd16);
        check("scan0_done_pulses", 32'(dones), 32'd1);
        check("scan0_recycles", 32'(recs), 32'd0);
        for (int i = 0; i < 16; i++) begin
            read_slot(i, x, y);
            check($sformatf("scan0_slot%0d_x", i), 32'(x), 32'((i * 47) % 360));
            check($sformatf("scan0_slot%0d_y", i), y, 32'(i * 40));
        end

        // 3. scan with minY=50: slots 0 and 1 recycle
        run_scan(32'd50, cycles, dones, recs);
        check("scan50_cycles", 32'(cycles), 32'd16);
        check("scan50_done_pulses", 32'(dones), 32'd1);
        check("scan50_recycles", 32'(recs), 32'd2);
        check("scan50_top_y", top_y, 32'd696);
        read_slot(0, x, y);
        check("scan50_slot0_x", 32'(x), 32'd225);
        check("scan50_slot0_y", y, 32'd663);
        read_slot(1, x, y);
        check("scan50_slot1_x", 32'(x), 32'd91);
        check("scan50_slot1_y", y, 32'd696);
        read_slot(2, x, y);
        check("scan50_slot2_x", 32'(x), 32'd94);
        check("scan50_slot2_y", y, 32'd80);

        // 4. second newView mid-scan: back-to-back scans
        minY        = 32'd0;
        newView     = 1'b1;
        step();
        busy_cnt    = busy ? 1 : 0;
        dones       = 0;
        first_done  = -1;
        second_done = -1;
        for (int i = 1; i <= 60; i++) begin
            newView = (i == 7);
            step();
            if (scan_done) begin
                dones++;
                if (first_done < 0) first_done = i;
                else second_done = i;
            end
            if (!busy) break;
            busy_cnt++;
        end
        newView = 1'b0;
        check("coalesce_done_pulses", 32'(dones), 32'd2);
        check("coalesce_first_done", 32'(first_done), 32'd16);
        check("coalesce_done_spacing", 32'(second_done - first_done), 32'd16);
        check("coalesce_busy_cycles", 32'(busy_cnt), 32'd32);
        check("coalesce_top_y", top_y, 32'd696);

        // 5. reset mid-scan, with an event pending: reinit, no scan follows
        minY    = 32'd1000;
        newView = 1'b1;
        step();
        newView = 1'b0;
        step();
        newView = 1'b1;
        step();
        newView = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_busy", 32'(busy), 32'd1);
        check("midreset_top_y_now", top_y, 32'd600);
        busy_cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) break;
            busy_cnt++;
        end
        check("midreset_init_cycles", 32'(busy_cnt), 32'd16);
        step();
        step();
        check("midreset_no_scan", 32'(busy), 32'd0);
        check("midreset_top_y", top_y, 32'd600);
        read_slot(0, x, y);
        check("midreset_slot0_x", 32'(x), 32'd0);
        check("midreset_slot0_y", y, 32'd0);

        // 6. read-port sweep during IDLE
        for (int i = 0; i < 16; i++) begin
            read_slot(i, x, y);
            check($sformatf("sweep_slot%0d_y", i), y, 32'(i * 40));
        end

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
